// File: rtl/pulse_event_scheduler.sv
// Round-robin scheduler that shares one extended-pulse channel among N_REQ event requesters.
// All sampling and state advance are qualified by the pixel clock enable ce.
module pulse_event_scheduler #(
  parameter int N_REQ       = 4,
  parameter int PULSE_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [N_REQ-1:0]         req_pulse,
  output logic                     pulse_out,
  output logic [$clog2(N_REQ)-1:0] pulse_id,
  output logic [N_REQ-1:0]         pending,
  output logic                     busy,
  output logic                     dropped
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ID_W-1:0]   last_id_reg;
  logic [ID_W-1:0]   pulse_id_reg;
  logic [N_REQ-1:0]  pending_reg;
  logic              pulse_out_reg;
  logic              dropped_reg;

  logic [N_REQ-1:0]  cand;
  logic              slot_free;
  logic              grant_en;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   probe_idx;
  logic [N_REQ-1:0]  grant_onehot;
  logic [N_REQ-1:0]  pending_next;
  logic              dropped_next;

  assign cand = pending_reg | (ce ? req_pulse : '0);

  // Walk from the offset furthest from last_id down to the nearest one, so the
  // requester right after the previous grant ends up winning.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      probe_idx = ID_W'((int'(last_id_reg) + k) % N_REQ);
      if (cand[probe_idx]) begin
        grant_found = 1'b1;
        grant_idx   = probe_idx;
      end
    end
  end

  assign slot_free = (state_reg == IDLE) || (count_reg == '0);
  assign grant_en  = ce && slot_free && grant_found;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_onehot[gi] = grant_en && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // A grant consumes the granted requester's event; everything else queues,
  // and a repeat event on an already-pending requester is merged and flagged.
  assign pending_next = cand & ~grant_onehot;
  assign dropped_next = |(req_pulse & pending_reg & ~grant_onehot);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      last_id_reg   <= ID_LAST;
      pulse_id_reg  <= '0;
      pending_reg   <= '0;
      pulse_out_reg <= 1'b0;
      dropped_reg   <= 1'b0;
    end else if (ce) begin
      pending_reg <= pending_next;
      dropped_reg <= dropped_next;
      if (grant_en) begin
        state_reg     <= ACTIVE;
        pulse_out_reg <= 1'b1;
        count_reg     <= CNT_LOAD;
        pulse_id_reg  <= grant_idx;
        last_id_reg   <= grant_idx;
      end else if (state_reg == ACTIVE) begin
        if (count_reg != '0) begin
          count_reg <= count_reg - 1'b1;
        end else begin
          state_reg     <= IDLE;
          pulse_out_reg <= 1'b0;
        end
      end
    end else begin
      dropped_reg <= 1'b0;
    end
  end

  assign pulse_out = pulse_out_reg;
  assign pulse_id  = pulse_id_reg;
  assign pending   = pending_reg;
  assign dropped   = dropped_reg;
  assign busy      = pulse_out_reg || (|pending_reg);

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Scoreboard bench for pulse_event_scheduler: directed scenarios plus random traffic,
// checked against a behavioural model that tracks remaining pulse length and a pending set.
module tb_pulse_event_scheduler;

  localparam int NR = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [NR-1:0] req_pulse;
  logic          pulse_out;
  logic [1:0]    pulse_id;
  logic [NR-1:0] pending;
  logic          busy;
  logic          dropped;

  pulse_event_scheduler #(.N_REQ(NR), .PULSE_WIDTH(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_pulse (req_pulse),
    .pulse_out (pulse_out),
    .pulse_id  (pulse_id),
    .pending   (pending),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            po;
    logic [1:0]    id;
    logic [NR-1:0] pend;
    bit            busy;
    bit            drop;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference: a pulse lasts PW enabled cycles after its grant; a new grant
  // is only possible once the current pulse has used up its last cycle.
  bit m_active;
  int m_left;
  int m_id;
  int m_last;
  bit m_pend [NR];
  bit m_drop;

  task automatic model_step(input bit r, input bit c, input logic [NR-1:0] q);
    bit free;
    int g;
    int idx;
    m_drop = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_left   = 0;
      m_id     = 0;
      m_last   = NR - 1;
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end else if (c) begin
      free = !m_active;
      if (m_active) begin
        m_left = m_left - 1;
        if (m_left == 0) free = 1'b1;
      end
      g = -1;
      if (free) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (g < 0 && (m_pend[idx] || q[idx])) g = idx;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (q[i] && m_pend[i] && i != g) m_drop = 1'b1;
        m_pend[i] = (m_pend[i] || q[i]) && (i != g);
      end
      if (g >= 0) begin
        m_active = 1'b1;
        m_left   = PW;
        m_id     = g;
        m_last   = g;
      end else if (free) begin
        m_active = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit c, input logic [NR-1:0] q);
    exp_t e;
    bit   any_p;
    @(negedge clk);
    rst       = r;
    ce        = c;
    req_pulse = q;
    model_step(r, c, q);
    any_p = 1'b0;
    for (int i = 0; i < NR; i++) begin
      e.pend[i] = m_pend[i];
      any_p     = any_p | m_pend[i];
    end
    e.po   = m_active;
    e.id   = 2'(m_id);
    e.busy = m_active | any_p;
    e.drop = m_drop;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0);
  endtask

  // Monitor: every edge that follows a driven cycle presents one output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (pulse_out !== e.po || pulse_id !== e.id || pending !== e.pend ||
            busy !== e.busy || dropped !== e.drop) begin
          n_fail++;
          $display("FAIL cycle_outputs #%0d: got po=%0b id=%0d pend=%b busy=%0b drop=%0b, want po=%0b id=%0d pend=%b busy=%0b drop=%0b",
                   n_cmp, pulse_out, pulse_id, pending, busy, dropped,
                   e.po, e.id, e.pend, e.busy, e.drop);
        end else begin
          $display("cmp #%0d ok po=%0b id=%0d pend=%b busy=%0b drop=%0b",
                   n_cmp, pulse_out, pulse_id, pending, busy, dropped);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] rq;
    rst = 1'b1;
    ce = 1'b0;
    req_pulse = '0;

    drive(1'b1, 1'b1, 4'b1111);
    drive(1'b1, 1'b0, 4'b0000);

    // single event, PW-long pulse, then idle
    drive(1'b0, 1'b1, 4'b0001);
    idle(5);

    // three simultaneous requests served back-to-back
    drive(1'b1, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'b1011);
    idle(12);

    // toggling clock enable stretches the pulse; events while ce=0 ignored
    drive(1'b0, 1'b1, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 4'($urandom_range(1, 15)));
      drive(1'b0, 1'b1, 4'b0000);
    end

    // double strobe on a pending requester while another is active
    drive(1'b0, 1'b1, 4'b0010);
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b1000);
    idle(8);

    // reset in the middle of a pulse, then a fresh event
    drive(1'b0, 1'b1, 4'b0011);
    drive(1'b0, 1'b1, 4'b0000);
    drive(1'b1, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b0100);
    idle(5);

    // two requesters hammering continuously
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 4'b0011);
    idle(8);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rq);
    end
    idle(10);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_event_scheduler.md
PULSE_EVENT_SCHEDULER -- requirements
Module: pulse_event_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of event requesters sharing one extended-pulse channel (legal 2..16).
REQ-002 SHALL have parameter PULSE_WIDTH, default 9, length of each granted pulse in ce-qualified cycles (legal 2..255).
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port ce  input  1  pixel clock enable; qualifies all event sampling and state advance.
REQ-006 SHALL have port req_pulse  input  N_REQ  per-requester event strobes, sampled only when ce=1.
REQ-007 SHALL have port pulse_out  output  1  extended pulse, high while a grant is active.
REQ-008 SHALL have port pulse_id  output  $clog2(N_REQ)  index of current/most recent grant.
REQ-009 SHALL have port pending  output  N_REQ  registered per-requester pending flags.
REQ-010 SHALL have port busy  output  1  high when state is ACTIVE or any pending bit set.
REQ-011 SHALL have port dropped  output  1  one-clk flag: an event was merged into an already-pending request.

Function
REQ-012 SHALL implement FSM states IDLE and ACTIVE; pulse_out = (state==ACTIVE), registered.
REQ-013 SHALL form cand = pending | (ce ? req_pulse : 0) each clk cycle.
REQ-014 SHALL, in IDLE on a ce=1 cycle with cand!=0, grant the first set bit of cand searching from last_id+1 upward with wrap-around, go ACTIVE at next edge, load count=PULSE_WIDTH-1, set pulse_id and last_id to the granted index.
REQ-015 SHALL, in ACTIVE on a ce=1 cycle with count!=0, decrement count; on ce=1 with count==0, either grant the next request per REQ-014 (remain ACTIVE, back-to-back, no low gap) or return to IDLE if cand==0.
REQ-016 SHALL hold pulse_out high for exactly PULSE_WIDTH ce=1 cycles per grant, independent of the number of ce=0 cycles interleaved.
REQ-017 SHALL give latency of one clk edge from a sampled event in IDLE to pulse_out=1.
REQ-018 SHALL clear the granted requester's pending bit at the grant edge; an event arriving for that requester in the grant cycle is consumed by the grant, not re-queued, and does not set dropped.
REQ-019 SHALL set pending[i] for a sampled event on requester i not granted that cycle, including the requester currently ACTIVE (re-served later in round-robin order).
REQ-020 SHALL assert dropped for one clk when a sampled event hits requester i with pending[i] already 1 and i not granted that cycle; pending[i] stays 1.
REQ-021 SHALL freeze state, count, pending, pulse_id, last_id when ce=0; req_pulse ignored; dropped=0.
REQ-022 SHALL keep pulse_id at last granted value while IDLE.

Reset
REQ-023 SHALL on rst=1 at clk edge set state=IDLE, pulse_out=0, pulse_id=0, pending=0, busy=0, dropped=0, count=0, last_id=N_REQ-1 (requester 0 highest first priority).
REQ-024 SHALL take precedence over ce and events; reset mid-pulse drops pulse_out next edge; events in reset cycles discarded.

Verification (N_REQ=4, PULSE_WIDTH=3 unless noted)
REQ-025 SHALL cover: ce=1 constant, req_pulse=0001 one cycle -> pulse_out high exactly 3 clks starting next edge, pulse_id=0, then IDLE, busy=0.
REQ-026 SHALL cover: req_pulse=1011 in one ce cycle from reset -> grants 0,1,3 back-to-back, pulse_out high 9 consecutive clks, pending 1010->1000->0000.
REQ-027 SHALL cover: ce toggling 1,0,1,0..., single event req 2 -> pulse_out high for 3 ce=1 cycles (6 clks), req_pulse during ce=0 ignored.
REQ-028 SHALL cover: while req 1 ACTIVE, req 3 strobed twice -> pending=1000, dropped pulses once on second strobe, req 3 served after req 1 ends.
REQ-029 SHALL cover: rst asserted in 2nd cycle of active pulse -> pulse_out=0, pending=0, pulse_id=0 next edge; next event req 2 granted with normal 1-clk latency.
REQ-030 SHALL cover round-robin fairness: requesters 0 and 1 re-strobed continuously -> grants alternate 0,1,0,1, never two consecutive to one requester while the other pends.
